// File: rtl/sdram_init_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_init_ctrl: SDR SDRAM power-up sequencer (wait, PRECHARGE ALL,        |
// | AUTO REFRESH xN, LOAD MODE REGISTER). Revision 1.0                         |
// +----------------------------------------------------------------------------+
module sdram_init_ctrl #(
    parameter int T_POWER  = 20000,
    parameter int T_RP     = 2,
    parameter int T_RFC    = 7,
    parameter int T_MRD    = 3,
    parameter int AREF_NUM = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    output logic [3:0]  init_cmd,
    output logic [1:0]  init_ba,
    output logic [12:0] init_addr,
    output logic        init_end
);

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [3:0]  CMD_LMR  = 4'b0000;
    localparam logic [1:0]  BA_IDLE   = 2'b11;
    localparam logic [12:0] ADDR_IDLE = 13'h1FFF;
    // Burst write = programmed, CL=3, sequential, full-page burst
    localparam logic [12:0] MODE_REG  = 13'b000_0_00_011_0_111;

    localparam int MAX_A  = (T_POWER > T_RFC) ? T_POWER : T_RFC;
    localparam int MAX_B  = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = $clog2(MAX_T + 1);
    localparam int REF_W  = $clog2(AREF_NUM + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        TRP  = 3'd2,
        AREF = 3'd3,
        TRFC = 3'd4,
        MRS  = 3'd5,
        TMRD = 3'd6,
        END  = 3'd7
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [REF_W-1:0]   ref_cnt;

    // Outputs are loaded on the transition edge so each command lands in
    // the first cycle of its state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ref_cnt   <= '0;
            init_cmd  <= CMD_NOP;
            init_ba   <= BA_IDLE;
            init_addr <= ADDR_IDLE;
            init_end  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cnt == CNT_W'(T_POWER - 1)) begin
                        state    <= PRE;
                        cnt      <= '0;
                        init_cmd <= CMD_PRE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRE: begin
                    state    <= TRP;
                    cnt      <= '0;
                    init_cmd <= CMD_NOP;
                end
                TRP: begin
                    if (cnt == CNT_W'(T_RP - 1)) begin
                        state    <= AREF;
                        cnt      <= '0;
                        init_cmd <= CMD_AREF;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                AREF: begin
                    state    <= TRFC;
                    cnt      <= '0;
                    ref_cnt  <= ref_cnt + REF_W'(1);
                    init_cmd <= CMD_NOP;
                end
                TRFC: begin
                    if (cnt == CNT_W'(T_RFC - 1)) begin
                        cnt <= '0;
                        if (ref_cnt < REF_W'(AREF_NUM)) begin
                            state    <= AREF;
                            init_cmd <= CMD_AREF;
                        end else begin
                            state     <= MRS;
                            init_cmd  <= CMD_LMR;
                            init_ba   <= 2'b00;
                            init_addr <= MODE_REG;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MRS: begin
                    state     <= TMRD;
                    cnt       <= '0;
                    init_cmd  <= CMD_NOP;
                    init_ba   <= BA_IDLE;
                    init_addr <= ADDR_IDLE;
                end
                TMRD: begin
                    if (cnt == CNT_W'(T_MRD - 1)) begin
                        state    <= END;
                        cnt      <= '0;
                        init_end <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                END: begin
                    init_cmd <= CMD_NOP;
                    init_end <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_ctrl.sv
`default_nettype none
// Directed bench for sdram_init_ctrl: two default-parameter instances
// (full sequence + hold, mid-refresh reset) and one shortened instance.
module tb_sdram_init_ctrl;

    logic        clk;
    logic        rst_n [3];
    logic [3:0]  cmd   [3];
    logic [1:0]  ba    [3];
    logic [12:0] addr  [3];
    logic        done  [3];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int pre_n, pre_at, aref_n, aref_first, aref_last, gap_err;
        int mr_n, mr_at, mr_addr, mr_ba, end_at, bus_err, bad_cmd;
    } seq_t;

    sdram_init_ctrl dut0 (.sys_clk(clk), .sys_rst_n(rst_n[0]), .init_cmd(cmd[0]),
                          .init_ba(ba[0]), .init_addr(addr[0]), .init_end(done[0]));
    sdram_init_ctrl dut1 (.sys_clk(clk), .sys_rst_n(rst_n[1]), .init_cmd(cmd[1]),
                          .init_ba(ba[1]), .init_addr(addr[1]), .init_end(done[1]));
    sdram_init_ctrl #(.T_POWER(10), .AREF_NUM(2)) dut2 (
                          .sys_clk(clk), .sys_rst_n(rst_n[2]), .init_cmd(cmd[2]),
                          .init_ba(ba[2]), .init_addr(addr[2]), .init_end(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Releases reset at a falling edge; sample k is taken k rising edges later.
    task automatic run_seq(input int idx, input int budget, output seq_t s);
        s = '{default: 0};
        s.end_at = -1;
        @(negedge clk);
        rst_n[idx] = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            case (cmd[idx])
                4'b0111: if (ba[idx] !== 2'b11 || addr[idx] !== 13'h1FFF) s.bus_err++;
                4'b0010: begin
                    s.pre_n++;
                    if (s.pre_n == 1) s.pre_at = k;
                    if (ba[idx] !== 2'b11 || addr[idx] !== 13'h1FFF) s.bus_err++;
                end
                4'b0001: begin
                    s.aref_n++;
                    if (s.aref_n == 1) s.aref_first = k;
                    else if (k - s.aref_last != 8) s.gap_err++;
                    s.aref_last = k;
                    if (ba[idx] !== 2'b11 || addr[idx] !== 13'h1FFF) s.bus_err++;
                end
                4'b0000: begin
                    s.mr_n++;
                    s.mr_at   = k;
                    s.mr_addr = int'(addr[idx]);
                    s.mr_ba   = int'(ba[idx]);
                end
                default: s.bad_cmd++;
            endcase
            if (done[idx] === 1'b1) begin
                s.end_at = k;
                break;
            end
        end
    endtask

    initial begin
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        rst_n[2] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd",  32'(cmd[0]),  32'h7);
        check("rst_ba",   32'(ba[0]),   32'h3);
        check("rst_addr", 32'(addr[0]), 32'h1FFF);
        check("rst_end",  32'(done[0]), 32'h0);

        fork
            begin : full_run
                seq_t s;
                int viol;
                run_seq(0, 21000, s);
                check("pre_at",     s.pre_at,     20000);
                check("pre_n",      s.pre_n,      1);
                check("aref_n",     s.aref_n,     8);
                check("aref_first", s.aref_first, 20003);
                check("aref_gap",   s.gap_err,    0);
                check("mr_n",       s.mr_n,       1);
                check("mr_at",      s.mr_at,      s.aref_last + 8);
                check("mr_addr",    s.mr_addr,    32'h0037);
                check("mr_ba",      s.mr_ba,      0);
                check("end_at",     s.end_at,     20071);
                check("end_gap",    s.end_at - s.mr_at, 4);
                check("idle_bus",   s.bus_err,    0);
                check("bad_cmd",    s.bad_cmd,    0);
                viol = 0;
                for (int k = 0; k < 50000; k++) begin
                    @(negedge clk);
                    if (done[0] !== 1'b1 || cmd[0] !== 4'b0111 ||
                        ba[0] !== 2'b11 || addr[0] !== 13'h1FFF) viol++;
                end
                check("hold_end", viol, 0);
            end
            begin : mid_reset
                seq_t s;
                @(negedge clk);
                rst_n[1] = 1'b1;
                // Fifth AUTO REFRESH is on the bus at sample 20035.
                for (int k = 1; k <= 20035; k++) @(negedge clk);
                check("pre_rst_cmd", 32'(cmd[1]), 32'h1);
                #2 rst_n[1] = 1'b0;
                #1;
                check("async_cmd",  32'(cmd[1]),  32'h7);
                check("async_ba",   32'(ba[1]),   32'h3);
                check("async_addr", 32'(addr[1]), 32'h1FFF);
                check("async_end",  32'(done[1]), 32'h0);
                repeat (3) @(posedge clk);
                run_seq(1, 21000, s);
                check("rerun_pre",  s.pre_at, 20000);
                check("rerun_aref", s.aref_n, 8);
                check("rerun_end",  s.end_at, 20071);
            end
            begin : short_run
                seq_t s;
                run_seq(2, 200, s);
                check("sh_pre_at",  s.pre_at,     10);
                check("sh_aref_n",  s.aref_n,     2);
                check("sh_aref1",   s.aref_first, 13);
                check("sh_aref_gap", s.gap_err,   0);
                check("sh_mr_at",   s.mr_at,      29);
                check("sh_mr_addr", s.mr_addr,    32'h0037);
                check("sh_end_at",  s.end_at,     33);
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
